// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and its decoder neighbour.
package riscv_pkg;

  typedef enum logic [6:0] {
    LW     = 7'b0000011,
    SW     = 7'b0100011,
    R_TYPE = 7'b0110011,
    BEQ    = 7'b1100011
  } opcode_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction with its PC until decode takes it.
import riscv_pkg::*;

module if_id_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_pc_plus4,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  // Flush wins over both a new load and a consume in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (load && !flush) begin
        instr    <= load_instr;
        pc       <= load_pc;
        pc_plus4 <= load_pc_plus4;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time and
// buffers the returned word for decode. Handshake: id_valid & id_ready = consume.
import riscv_pkg::*;

module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [6:0]      id_op_code,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7
);

  fetch_state_t    state, next_state;
  logic [XLEN-1:0] pc, next_pc;
  logic            load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= next_pc;
      misalign <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end

  // Redirect overrides every other event; an already granted request must
  // still have its response drained, hence DISCARD.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    load       = 1'b0;
    case (state)
      REQ: begin
        if (imem_gnt) next_state = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          next_state = imem_rvalid ? REQ : DISCARD;
        end else if (imem_rvalid) begin
          next_state = HOLD;
          load       = 1'b1;
          next_pc    = pc + XLEN'(4);
        end
      end
      HOLD: begin
        if (redirect || (id_valid && id_ready)) next_state = REQ;
      end
      DISCARD: begin
        if (imem_rvalid) next_state = REQ;
      end
      default: next_state = REQ;
    endcase
    if (redirect) next_pc = redirect_pc & ~XLEN'(3);
  end

  assign imem_req  = rst_n && (state == REQ);
  assign imem_addr = pc;

  if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .flush         (redirect),
    .ready         (id_ready),
    .load_instr    (imem_rdata),
    .load_pc       (pc),
    .load_pc_plus4 (pc + XLEN'(4)),
    .valid         (id_valid),
    .instr         (id_instr),
    .pc            (id_pc),
    .pc_plus4      (id_pc_plus4)
  );

  assign id_op_code = id_instr[6:0];
  assign id_funct3  = id_instr[14:12];
  assign id_funct7  = id_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected IF/ID contents.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_op_code;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .misalign    (misalign),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_op_code  (id_op_code),
    .id_funct3   (id_funct3),
    .id_funct7   (id_funct7)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in a REQ cycle; returns in the cycle the word sits in IF/ID.
  task automatic do_fetch(input logic [31:0] word, input logic [31:0] addr,
                          input int gnt_wait, input bit push);
    for (int i = 0; i < gnt_wait; i++) begin
      imem_gnt = 1'b0;
      @(negedge clk);
      check("req_before_gnt", imem_req, 1'b1);
      check("addr_before_gnt", imem_addr, addr);
      tick();
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    check("req_at_gnt", imem_req, 1'b1);
    check("addr_at_gnt", imem_addr, addr);
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    if (push) exp_q.push_back({word, addr, addr + 32'd4});
    tick();
    imem_rvalid = 1'b0;
  endtask

  // Monitor: every consumed instruction must match the oldest expected entry.
  always @(negedge clk) begin
    logic [95:0] e;
    logic [31:0] w;
    if (rst_n && id_valid && id_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got instr %0h pc %0h expected none", id_instr, id_pc);
      end else begin
        e = exp_q.pop_front();
        w = e[95:64];
        check("mon_entry", {id_instr, id_pc, id_pc_plus4}, e);
        check("mon_fields", {id_op_code, id_funct3, id_funct7}, {w[6:0], w[14:12], w[31:25]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", id_valid, 1'b0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", id_pc, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    tick();
    rst_n    = 1'b1;
    id_ready = 1'b1;

    // 1: first fetch, LW
    do_fetch(32'h0000_2083, 32'h0, 0, 1'b1);
    @(negedge clk);
    check("t1_valid", id_valid, 1'b1);
    check("t1_op_code", id_op_code, 7'b0000011);
    check("t1_pc", id_pc, 32'h0);
    check("t1_pc_plus4", id_pc_plus4, 32'h4);
    tick();

    // 2: decode stalls for 5 cycles
    id_ready = 1'b0;
    do_fetch(32'h0020_81b3, 32'h4, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid_held", id_valid, 1'b1);
      check("t2_instr_held", id_instr, 32'h0020_81b3);
      check("t2_pc_held", id_pc, 32'h4);
      check("t2_req_low", imem_req, 1'b0);
      tick();
    end
    id_ready = 1'b1;
    tick();

    // 3: redirect in WAIT, stale response two cycles later
    imem_gnt = 1'b1;
    @(negedge clk);
    check("t2_req_after_ready", imem_req, 1'b1);
    check("t2_addr_after_ready", imem_addr, 32'h8);
    tick();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t3_discard_no_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    tick();
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("t3_stale_dropped", id_valid, 1'b0);
    check("t3_req", imem_req, 1'b1);
    check("t3_addr", imem_addr, 32'h100);
    tick();
    do_fetch(32'h0020_a023, 32'h100, 1, 1'b1);
    tick();

    // 4: redirect coincident with rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    @(negedge clk);
    check("t4_valid_low", id_valid, 1'b0);
    check("t4_req", imem_req, 1'b1);
    check("t4_addr", imem_addr, 32'h200);
    tick();
    do_fetch(32'h0020_8463, 32'h200, 0, 1'b1);
    tick();

    // 5: misaligned redirect while waiting for gnt
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    check("t5_misalign_pre", misalign, 1'b0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t5_misalign_pulse", misalign, 1'b1);
    check("t5_req", imem_req, 1'b1);
    check("t5_addr", imem_addr, 32'h100);
    tick();
    @(negedge clk);
    check("t5_misalign_end", misalign, 1'b0);
    tick();
    do_fetch(32'h00a0_0093, 32'h100, 2, 1'b1);
    tick();

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    do_fetch(32'h0010_8113, 32'hFFFF_FFFC, 0, 1'b1);
    @(negedge clk);
    check("wrap_pc_plus4", id_pc_plus4, 32'h0);
    tick();

    // Redirect in HOLD drops the buffered word even with id_ready high
    id_ready = 1'b0;
    do_fetch(32'h0000_0033, 32'h0, 0, 1'b0);
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    check("flush_valid_before", id_valid, 1'b1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("flush_valid_after", id_valid, 1'b0);
    check("flush_addr", imem_addr, 32'h40);
    tick();

    // 6: gnt held low, then reset mid-WAIT
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_req_held", imem_req, 1'b1);
      check("t6_addr_held", imem_addr, 32'h40);
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", id_valid, 1'b0);
    check("t6_rst_req", imem_req, 1'b0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    tick();
    imem_rvalid = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    check("t6_post_req", imem_req, 1'b1);
    check("t6_post_addr", imem_addr, 32'h0);
    check("t6_post_valid", id_valid, 1'b0);
    tick();
    do_fetch(32'h0041_2183, 32'h0, 0, 1'b1);
    tick();
    tick();
    @(negedge clk);
    check("queue_empty", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
